// File: rtl/msf_pkg.sv
// MSF decoder shared types: FSM states, second patterns
// and the per-second symbol bundle.
package msf_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_e;

  localparam logic [9:0] PAT_00     = 10'b1000000000;
  localparam logic [9:0] PAT_10     = 10'b1100000000;
  localparam logic [9:0] PAT_01     = 10'b1010000000;
  localparam logic [9:0] PAT_11     = 10'b1110000000;
  localparam logic [9:0] PAT_MARKER = 10'b1111100000;

  typedef struct packed {
    logic is_marker;
    logic a;
    logic b;
    logic err;
  } symbol_t;

endpackage

// File: rtl/msf_symbol_classify.sv
// Maps one 10-slot carrier window (slot 0 = MSB)
// onto an MSF symbol.
import msf_pkg::*;

module msf_symbol_classify (
  input  logic [9:0] win_i,
  output symbol_t    sym_o
);

  always_comb begin
    sym_o = '0;
    case (win_i)
      PAT_00:     ;
      PAT_10:     sym_o.a = 1'b1;
      PAT_01:     sym_o.b = 1'b1;
      PAT_11: begin
        sym_o.a = 1'b1;
        sym_o.b = 1'b1;
      end
      PAT_MARKER: sym_o.is_marker = 1'b1;
      default:    sym_o.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/msf_frame_decoder.sv
// Frames the 10 Hz carrier samples into seconds and
// emits one decoded MSF symbol per second.
import msf_pkg::*;

module msf_frame_decoder #(
  parameter int SAMPLES_PER_SEC = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_valid_i,
  input  logic       sample_data_i,
  output logic       bits_valid_o,
  output logic       bits_is_second_00_o,
  output logic [1:0] bits_data_o,
  output logic       locked_o,
  output logic       error_o
);

  if (SAMPLES_PER_SEC != 10) begin : g_bad_rate
    $error("msf_frame_decoder: SAMPLES_PER_SEC must be 10");
  end

  state_e     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [9:0] win_q, win_d;
  logic [9:0] win_upd;
  logic       prev_q, prev_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       marker_q, marker_d;
  logic [1:0] data_q, data_d;
  logic       locked_q, locked_d;
  symbol_t    sym;

  msf_symbol_classify u_classify (
    .win_i (win_upd),
    .sym_o (sym)
  );

  always_comb begin
    win_upd = win_q;
    win_upd[4'd9 - slot_q] = sample_data_i;
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    win_d    = win_q;
    prev_d   = prev_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    marker_d = marker_q;
    data_d   = data_q;
    locked_d = locked_q;
    if (sample_valid_i) begin
      unique case (state_q)
        HUNT: begin
          prev_d = sample_data_i;
          if (!prev_q && sample_data_i) begin
            win_d   = PAT_00;
            slot_d  = 4'd1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          win_d = win_upd;
          if (slot_q == 4'd9) begin
            slot_d = 4'd0;
            if (sym.err) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              prev_d   = 1'b0;
              state_d  = HUNT;
            end else begin
              valid_d  = 1'b1;
              marker_d = sym.is_marker;
              data_d   = {sym.a, sym.b};
              locked_d = 1'b1;
              state_d  = CHECK;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        CHECK: begin
          if (sample_data_i) begin
            win_d   = PAT_00;
            slot_d  = 4'd1;
            state_d = COLLECT;
          end else begin
            // lost the second boundary; a 1 next re-arms at once
            err_d    = 1'b1;
            locked_d = 1'b0;
            prev_d   = 1'b0;
            state_d  = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HUNT;
      slot_q   <= 4'd0;
      win_q    <= '0;
      prev_q   <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      marker_q <= 1'b0;
      data_q   <= 2'b00;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      win_q    <= win_d;
      prev_q   <= prev_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      marker_q <= marker_d;
      data_q   <= data_d;
      locked_q <= locked_d;
    end
  end

  assign bits_valid_o        = valid_q;
  assign bits_is_second_00_o = marker_q;
  assign bits_data_o         = data_q;
  assign locked_o            = locked_q;
  assign error_o             = err_q;

endmodule
